pwm_generator: RTL and testbench
================================

Name: pwm_generator

Overview:
Downstream consumer of the duty-cycle controller. It takes the 7-bit duty_cycle percentage (0-100) and produces a 100-step PWM waveform on pwm_out. A prescaler sets the step rate. Duty is double-buffered and changes only at period boundaries, with an optional slew-limited ramp. An enable FSM guarantees that a PWM period is never truncated on shutdown.

Parameters:
CLK_DIV, 1000, system clocks per PWM step (legal range 1..65535); 100 MHz clk gives a 1 kHz PWM period
RAMP_STEP, 0, max change of duty_active per period; 0 means the target is applied immediately
ACTIVE_HIGH, 1, 1: pwm_out active level is 1; 0: pwm_out inverted, idle level becomes 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
enable  in  1  level; 1 requests PWM running
duty_cycle  in  7  target duty in percent (0-100); values 101-127 are clamped to 100
pwm_out  out  1  registered PWM output
period_start  out  1  one-clk pulse at the start of each PWM period
duty_active  out  7  duty currently applied, 0-100
busy  out  1  high whenever state != OFF

Behaviour:
- Reset (rst=0, async): state=OFF, prescaler=0, step=0, duty_active=0, period_start=0, busy=0, pwm_out=idle level (0 if ACTIVE_HIGH else 1). The output goes idle immediately, including mid-period.
- Prescaler: counts 0..CLK_DIV-1 in RUN/STOP. tick=1 when count==CLK_DIV-1, then count wraps to 0. With CLK_DIV=1, tick=1 every clk. Held at 0 in OFF.
- Step counter: 0..99, advances on tick, wraps 99->0. Held at 0 in OFF.
- Boundary edge is either of:
  - OFF->RUN transition edge, or
  - a tick with step==99 while in RUN.
- At each boundary edge:
  - tgt = min(duty_cycle, 100).
  - If RAMP_STEP==0: duty_active<=tgt.
  - Otherwise duty_active moves toward tgt by min(RAMP_STEP, |tgt-duty_active|).
  - duty_cycle is sampled only at boundaries; changes mid-period have no effect until the next boundary.
- period_start: registered, high for exactly the one clk following each boundary edge.
- pwm_out: registered active level when state in {RUN, STOP} and step < duty_active; otherwise idle level.
  - One clk latency relative to the step/duty registers.
  - duty_active=0 gives no active cycles; duty_active=100 gives continuously active, with no glitch across boundaries.
- FSM (OFF, RUN, STOP):
  - OFF -> RUN: enable=1. This is a boundary edge; prescaler=0, step=0.
  - RUN -> STOP: enable=0 and not at a tick with step==99.
  - RUN -> OFF: enable=0 at a tick with step==99. The period completes; no new boundary is taken.
  - STOP -> OFF: tick with step==99 while enable=0. duty_active<=0 on that edge.
  - STOP -> RUN: enable=1. Counting continues uninterrupted; the next period boundary is taken normally.
  - OFF always forces duty_active=0, so any ramp restarts from 0 (soft start).
- Width rules:
  - Prescaler is clog2(CLK_DIV) bits, minimum 1. Step counter is 7 bits.
  - Ramp arithmetic is done in 8 bits, so the result never leaves 0..100.

Decomposition:
- Package pwm_pkg holds:
  - constants PWM_STEPS=100, DUTY_W=7, DUTY_MAX=100;
  - the state enum {OFF, RUN, STOP};
  - a clamp function for duty_cycle.
- One sub-module, pwm_prescaler (params CLK_DIV; ports clk, rst, run, tick), generates the step tick. Step counter, FSM, duty buffer and output register stay in pwm_generator.

Test Plan:
1. CLK_DIV=1, RAMP_STEP=0, duty=50, enable=1 -> pwm_out high 50 clks then low 50 clks, repeating; period_start every 100 clks; duty_active=50.
2. Running at duty=50, change duty_cycle to 20 at step 10 -> current period still has 50 active steps, next period has 20; duty_active changes at the boundary only.
3. duty=0, then 100, then 120 -> 0 gives pwm_out never active; 100 gives pwm_out continuously active across 3 boundaries; 120 gives duty_active=100 with the same waveform as 100.
4. RAMP_STEP=5, enable from OFF with duty=50 -> duty_active 5,10,...,50 over the first 10 periods. Then set duty=47 -> duty_active=47 at the next boundary.
5. CLK_DIV=4, drop enable at step 30 -> busy stays 1 and the period completes to step 99, then state=OFF, busy=0, pwm idle. Repeat, but re-assert enable at step 60 in STOP -> no gap in counting; next period_start at the normal time.
6. Pull rst low at step 40 with pwm_out active -> pwm_out idle immediately (async), duty_active=0, busy=0. With ACTIVE_HIGH=0, idle level is 1 and duty=30 gives 30 low steps per period.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants, FSM state type and duty clamp for the PWM generator.
package pwm_pkg;

   localparam int PWM_STEPS = 100;
   localparam int DUTY_W    = 7;
   localparam int DUTY_MAX  = 100;

   typedef enum logic [1:0] {OFF, RUN, STOP} pwm_state_e;

   function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
      return (d > DUTY_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : d;
   endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Step-rate prescaler: one-clk tick every CLK_DIV clocks while run is high.
module pwm_prescaler #(
   parameter int CLK_DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = run && (cnt == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (!run || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/pwm_generator.sv
// 100-step PWM with double-buffered, optionally slew-limited duty and an
// enable FSM that always lets the current period finish before going idle.
module pwm_generator
   import pwm_pkg::*;
#(
   parameter int CLK_DIV     = 1000,
   parameter int RAMP_STEP   = 0,
   parameter bit ACTIVE_HIGH = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [DUTY_W-1:0] duty_cycle,
   output logic              pwm_out,
   output logic              period_start,
   output logic [DUTY_W-1:0] duty_active,
   output logic              busy
);

   localparam logic ACT_LVL  = ACTIVE_HIGH;
   localparam logic IDLE_LVL = ~ACTIVE_HIGH;
   localparam int   RAMP_LIM = (RAMP_STEP > DUTY_MAX) ? DUTY_MAX : RAMP_STEP;
   localparam logic [7:0] RAMP8 = 8'(RAMP_LIM);

   pwm_state_e        state, state_nxt;
   logic              tick, last_step, boundary;
   logic [DUTY_W-1:0] step, duty_nxt;
   logic [7:0]        tgt, cur, diff, stp;

   pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .run  (state != OFF),
      .tick (tick)
   );

   assign last_step = tick && (step == DUTY_W'(PWM_STEPS - 1));
   assign busy      = (state != OFF);

   // A re-enable landing on the last step of a STOP period still opens a
   // fresh period, so every period begins with a boundary.
   always_comb begin
      state_nxt = state;
      boundary  = 1'b0;
      case (state)
         OFF:  if (enable) begin
                  state_nxt = RUN;
                  boundary  = 1'b1;
               end
         RUN:  if (!enable)
                  state_nxt = last_step ? OFF : STOP;
               else
                  boundary = last_step;
         STOP: if (enable) begin
                  state_nxt = RUN;
                  boundary  = last_step;
               end else if (last_step)
                  state_nxt = OFF;
         default: state_nxt = OFF;
      endcase
   end

   // 8-bit ramp keeps the intermediate difference unsigned and in range.
   always_comb begin
      tgt      = {1'b0, clamp_duty(duty_cycle)};
      cur      = {1'b0, duty_active};
      diff     = (tgt > cur) ? (tgt - cur) : (cur - tgt);
      stp      = (RAMP_LIM == 0 || diff < RAMP8) ? diff : RAMP8;
      duty_nxt = (tgt > cur) ? DUTY_W'(cur + stp) : DUTY_W'(cur - stp);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= OFF;
         step         <= '0;
         duty_active  <= '0;
         period_start <= 1'b0;
         pwm_out      <= IDLE_LVL;
      end else begin
         state        <= state_nxt;
         period_start <= boundary;
         if (state_nxt == OFF)
            duty_active <= '0;
         else if (boundary)
            duty_active <= duty_nxt;
         if (state == OFF)
            step <= '0;
         else if (tick)
            step <= (step == DUTY_W'(PWM_STEPS - 1)) ? '0 : step + 7'd1;
         pwm_out <= (state != OFF && step < duty_active) ? ACT_LVL : IDLE_LVL;
      end
   end

endmodule

// File: tb/tb_pwm_generator.sv
// Randomized scoreboard bench: two PWM configurations share stimulus and are
// checked against a period-level reference model.
module tb_pwm_generator;

   localparam int DIV0 = 1, RAMP0 = 0;
   localparam int DIV1 = 3, RAMP1 = 5;

   logic             clk, rst, enable;
   logic [6:0]       duty_cycle;
   logic [1:0]       pwm, ps, bsy;
   logic [1:0][6:0]  da;

   int checks = 0;
   int errors = 0;

   // reference model state (per instance)
   bit on_m[2];
   int t_m[2], d_m[2];
   int q[2][$];

   // monitor state
   int cnt[2], cur[2];
   bit have[2], pbsy[2];

   pwm_generator #(.CLK_DIV(DIV0), .RAMP_STEP(RAMP0), .ACTIVE_HIGH(1'b1)) u_dut0 (
      .clk(clk), .rst(rst), .enable(enable), .duty_cycle(duty_cycle),
      .pwm_out(pwm[0]), .period_start(ps[0]), .duty_active(da[0]), .busy(bsy[0]));

   pwm_generator #(.CLK_DIV(DIV1), .RAMP_STEP(RAMP1), .ACTIVE_HIGH(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .enable(enable), .duty_cycle(duty_cycle),
      .pwm_out(pwm[1]), .period_start(ps[1]), .duty_active(da[1]), .busy(bsy[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int div_of(input int i);
      return (i == 0) ? DIV0 : DIV1;
   endfunction

   function automatic int ramp_of(input int i);
      return (i == 0) ? RAMP0 : RAMP1;
   endfunction

   function automatic logic act_of(input int i);
      return (i == 0) ? 1'b1 : 1'b0;
   endfunction

   // duty applied at a period start: clamp, then slew toward target
   function automatic int next_duty(input int i, input int now, input int req);
      int tgt, r, d;
      tgt = (req > 100) ? 100 : req;
      r   = ramp_of(i);
      if (r == 0) return tgt;
      d = (tgt > now) ? tgt - now : now - tgt;
      if (d > r) d = r;
      return (tgt > now) ? now + d : now - d;
   endfunction

   task automatic chk(input bit ok, input string nm, input int i, input int a, input int e);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s inst%0d t=%0t got %0d want %0d", nm, i, $time, a, e);
      end
   endtask

   // period-level reference model
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            on_m[i] = 1'b0; t_m[i] = 0; d_m[i] = 0;
            q[i].delete();
         end else if (!on_m[i]) begin
            if (enable) begin
               on_m[i] = 1'b1; t_m[i] = 0;
               d_m[i] = next_duty(i, 0, int'(duty_cycle));
               q[i].push_back(d_m[i]);
            end
         end else if (t_m[i] == 100 * div_of(i) - 1) begin
            t_m[i] = 0;
            if (enable) begin
               d_m[i] = next_duty(i, d_m[i], int'(duty_cycle));
               q[i].push_back(d_m[i]);
            end else begin
               on_m[i] = 1'b0; d_m[i] = 0;
            end
         end else begin
            t_m[i]++;
         end
      end
   end

   // monitor: pops expectations on period_start, tallies active clocks per period
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            chk(pwm[i] == ~act_of(i), "reset_pwm_idle", i, int'(pwm[i]), int'(~act_of(i)));
            chk(bsy[i] == 1'b0, "reset_busy", i, int'(bsy[i]), 0);
            chk(da[i] == 7'd0, "reset_duty_active", i, int'(da[i]), 0);
            chk(ps[i] == 1'b0, "reset_period_start", i, int'(ps[i]), 0);
            cnt[i] = 0; have[i] = 1'b0; pbsy[i] = 1'b0;
         end else begin
            if (pwm[i] == act_of(i)) cnt[i]++;
            if (ps[i]) begin
               chk(q[i].size() != 0, "period_start_expected", i, 1, q[i].size());
               if (q[i].size() != 0) begin
                  int e;
                  e = q[i].pop_front();
                  chk(int'(da[i]) == e, "duty_at_start", i, int'(da[i]), e);
                  if (have[i])
                     chk(cnt[i] == cur[i] * div_of(i), "active_clks", i, cnt[i], cur[i] * div_of(i));
                  cur[i] = e; have[i] = 1'b1; cnt[i] = 0;
               end
            end
            chk(q[i].size() == 0, "period_start_missing", i, 0, q[i].size());
            chk(bsy[i] == on_m[i], "busy", i, int'(bsy[i]), int'(on_m[i]));
            chk(int'(da[i]) == d_m[i], "duty_active", i, int'(da[i]), d_m[i]);
            if (!bsy[i] && pbsy[i]) begin
               if (have[i])
                  chk(cnt[i] == cur[i] * div_of(i), "last_period_clks", i, cnt[i], cur[i] * div_of(i));
               have[i] = 1'b0; cnt[i] = 0;
            end
            if (!bsy[i] && !pbsy[i])
               chk(pwm[i] == ~act_of(i), "idle_level", i, int'(pwm[i]), int'(~act_of(i)));
            pbsy[i] = bsy[i];
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   int dtab[6] = '{20, 0, 100, 120, 47, 30};

   initial begin
      rst = 1'b0; enable = 1'b0; duty_cycle = 7'd0;
      cyc(3);
      rst = 1'b1;
      cyc(5);
      // start from OFF, ramp instance climbs toward 50
      duty_cycle = 7'd50; enable = 1'b1;
      cyc(1000);
      // mid-period changes including 0, 100 and clamped 120
      foreach (dtab[k]) begin
         duty_cycle = 7'(dtab[k]);
         cyc($urandom_range(250, 450));
      end
      repeat (10) begin
         duty_cycle = 7'($urandom_range(0, 127));
         cyc($urandom_range(20, 400));
      end
      // shutdown / stop-resume at random points
      repeat (8) begin
         enable = 1'b0;
         cyc($urandom_range(5, 700));
         duty_cycle = 7'($urandom_range(0, 127));
         enable = 1'b1;
         cyc($urandom_range(5, 500));
      end
      // async reset while output is active
      duty_cycle = 7'd100;
      cyc(350);
      rst = 1'b0;
      cyc(3);
      rst = 1'b1;
      duty_cycle = 7'd30;
      cyc($urandom_range(400, 900));
      rst = 1'b0;
      cyc(2);
      rst = 1'b1;
      cyc(700);
      enable = 1'b0;
      cyc(800);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
